// File: rtl/chan_err_pkg.sv
// Shared types, LFSR constants and the popcount helper for the channel error injector.
package chan_err_pkg;

  typedef enum logic {GAP = 1'b0, BURST = 1'b1} inj_state_t;

  // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form.
  localparam logic [15:0] LFSR_POLY_16 = 16'hB400;
  localparam logic [15:0] LFSR_SEED    = 16'h0001;

  localparam int POP_W = 32;

  function automatic logic [5:0] popcount(input logic [POP_W-1:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/chan_err_lfsr.sv
// Right-shifting Galois LFSR that advances one state per step_i pulse.
module chan_err_lfsr
  import chan_err_pkg::*;
#(
  parameter int                 LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  POLY   = LFSR_W'(LFSR_POLY_16),
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(LFSR_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_o <= SEED;
    end else if (step_i) begin
      lfsr_o <= {1'b0, lfsr_o[LFSR_W-1:1]} ^ (lfsr_o[0] ? POLY : {LFSR_W{1'b0}});
    end
  end

endmodule

// File: rtl/chan_err_injector.sv
// Coded-symbol channel model: one register stage plus periodic (or LFSR-random) burst corruption.
// Random mode exists only when CHAN_ERR_LFSR_EN is defined; otherwise mode_i and thresh_i are ignored.
module chan_err_injector
  import chan_err_pkg::*;
#(
  parameter int SYM_W  = 2,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16,
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  burst_i,
  input  logic [SYM_W-1:0]  mask_i,
  input  logic [LFSR_W-1:0] thresh_i,
  input  logic              valid_i,
  input  logic [SYM_W-1:0]  sym_i,
  output logic              valid_o,
  output logic [SYM_W-1:0]  sym_o,
  output logic              err_o,
  output logic [STAT_W-1:0] err_sym_ct_o,
  output logic [STAT_W-1:0] err_bit_ct_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  inj_state_t         state, state_nx;
  logic [CNT_W-1:0]   phase_ct, phase_nx;
  logic [CNT_W-1:0]   period_sh, burst_sh;
  logic [SYM_W-1:0]   mask_sh;
  logic               load_cfg;
  logic               cfg_ok;
  logic               corrupt;
  logic [SYM_W-1:0]   cur_mask;
  logic               rand_mode;
  logic               rand_hit;
  logic [5:0]         flip_n;
  logic [STAT_W:0]    sym_sum;
  logic [STAT_W:0]    bit_sum;

`ifdef CHAN_ERR_LFSR_EN
  logic [LFSR_W-1:0]  lfsr;

  chan_err_lfsr #(
    .LFSR_W (LFSR_W),
    .POLY   (LFSR_W'(LFSR_POLY_16)),
    .SEED   (LFSR_W'(LFSR_SEED))
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step_i (valid_i),
    .lfsr_o (lfsr)
  );

  assign rand_mode = mode_i;
  assign rand_hit  = (lfsr < thresh_i);
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode_i, thresh_i};
  assign rand_mode  = 1'b0;
  assign rand_hit   = 1'b0;
`endif

  assign cfg_ok = (period_sh != CNT_ZERO) && (burst_sh != CNT_ZERO) &&
                  (mask_sh != {SYM_W{1'b0}});

  // Burst FSM next state and corruption decision. An unusable shadow config
  // keeps reloading so a fresh config is picked up without waiting for a GAP entry.
  always_comb begin
    state_nx = state;
    phase_nx = phase_ct;
    load_cfg = 1'b0;
    corrupt  = 1'b0;
    cur_mask = mask_sh;
    if (!en_i) begin
      state_nx = GAP;
      phase_nx = CNT_ZERO;
      load_cfg = 1'b1;
    end else if (rand_mode) begin
      state_nx = GAP;
      phase_nx = CNT_ZERO;
      load_cfg = 1'b1;
      cur_mask = mask_i;
      corrupt  = valid_i && rand_hit && (mask_i != {SYM_W{1'b0}});
    end else if (!cfg_ok) begin
      state_nx = GAP;
      phase_nx = CNT_ZERO;
      load_cfg = 1'b1;
    end else if (valid_i) begin
      case (state)
        GAP: begin
          if (phase_ct == period_sh - CNT_ONE) begin
            state_nx = BURST;
            phase_nx = CNT_ZERO;
          end else begin
            phase_nx = phase_ct + CNT_ONE;
          end
        end
        BURST: begin
          corrupt = 1'b1;
          if (phase_ct == burst_sh - CNT_ONE) begin
            state_nx = GAP;
            phase_nx = CNT_ZERO;
            load_cfg = 1'b1;
          end else begin
            phase_nx = phase_ct + CNT_ONE;
          end
        end
        default: begin
          state_nx = GAP;
          phase_nx = CNT_ZERO;
          load_cfg = 1'b1;
        end
      endcase
    end else begin
      state_nx = state;
    end
  end

  // FSM state, phase counter and shadow config (reset counts as a GAP entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GAP;
      phase_ct  <= CNT_ZERO;
      period_sh <= period_i;
      burst_sh  <= burst_i;
      mask_sh   <= mask_i;
    end else begin
      state    <= state_nx;
      phase_ct <= phase_nx;
      if (load_cfg) begin
        period_sh <= period_i;
        burst_sh  <= burst_i;
        mask_sh   <= mask_i;
      end
    end
  end

  // Output register stage; sym_o holds its value across invalid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      sym_o   <= {SYM_W{1'b0}};
      err_o   <= 1'b0;
    end else begin
      valid_o <= valid_i;
      err_o   <= corrupt;
      if (valid_i) begin
        sym_o <= corrupt ? (sym_i ^ cur_mask) : sym_i;
      end
    end
  end

  assign flip_n = popcount(POP_W'(cur_mask));

  // Candidate counter sums with a carry bit for saturation detection.
  always_comb begin
    sym_sum = {1'b0, err_sym_ct_o} + (STAT_W+1)'(1);
    bit_sum = {1'b0, err_bit_ct_o} + (STAT_W+1)'(flip_n);
  end

  // Saturating error statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sym_ct_o <= {STAT_W{1'b0}};
      err_bit_ct_o <= {STAT_W{1'b0}};
    end else if (corrupt) begin
      err_sym_ct_o <= sym_sum[STAT_W] ? {STAT_W{1'b1}} : sym_sum[STAT_W-1:0];
      err_bit_ct_o <= bit_sum[STAT_W] ? {STAT_W{1'b1}} : bit_sum[STAT_W-1:0];
    end
  end

endmodule

// File: tb/tb_chan_err_injector.sv
// Table-driven bench for chan_err_injector plus hand sequences for reset, reconfig and enable corners.
module tb_chan_err_injector;

  logic        clk = 1'b0;
  logic        rst, en_i, mode_i, valid_i;
  logic [7:0]  period_i, burst_i;
  logic [1:0]  mask_i, sym_i;
  logic [15:0] thresh_i;
  logic        valid_o, err_o, s_valid_o, s_err_o;
  logic [1:0]  sym_o, s_sym_o;
  logic [15:0] err_sym_ct_o, err_bit_ct_o;
  logic [3:0]  s_err_sym_ct_o, s_err_bit_ct_o;

  int checks = 0;
  int passes = 0;
  logic [1:0] last_sym;

  always #5 clk = ~clk;

  chan_err_injector dut (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .period_i(period_i),
    .burst_i(burst_i), .mask_i(mask_i), .thresh_i(thresh_i), .valid_i(valid_i),
    .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
    .err_sym_ct_o(err_sym_ct_o), .err_bit_ct_o(err_bit_ct_o)
  );

  chan_err_injector #(.STAT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .period_i(period_i),
    .burst_i(burst_i), .mask_i(mask_i), .thresh_i(thresh_i), .valid_i(valid_i),
    .sym_i(sym_i), .valid_o(s_valid_o), .sym_o(s_sym_o), .err_o(s_err_o),
    .err_sym_ct_o(s_err_sym_ct_o), .err_bit_ct_o(s_err_bit_ct_o)
  );

  typedef struct {
    logic       en;
    logic [7:0] period;
    logic [7:0] burst;
    logic [1:0] mask;
    logic       gaps;
    int         nsym;
    int         exp_sct;
    int         exp_bct;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_sym = 2'b00;
  endtask

  // One input cycle, then check the registered outputs just after the edge.
  task automatic send(input logic v, input logic [1:0] s, input logic bad,
                      input logic [1:0] m, input string name);
    logic [1:0] exp_sym;
    valid_i = v;
    sym_i = s;
    exp_sym = v ? (bad ? (s ^ m) : s) : last_sym;
    @(posedge clk);
    #1;
    check({name, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    check({name, "_err"}, {31'd0, err_o}, {31'd0, v & bad});
    check({name, "_sym"}, {30'd0, sym_o}, {30'd0, exp_sym});
    last_sym = exp_sym;
    valid_i = 1'b0;
  endtask

  task automatic set_cfg(input logic en, input logic [7:0] p, input logic [7:0] b,
                         input logic [1:0] m);
    en_i = en;
    period_i = p;
    burst_i = b;
    mask_i = m;
  endtask

  initial begin
    vec_t sc;
    int   sat_s, sat_b, cnt;
    logic bad;
    logic [1:0] s;

    rst = 1'b0; en_i = 1'b0; mode_i = 1'b0; valid_i = 1'b0;
    period_i = 8'd0; burst_i = 8'd0; mask_i = 2'b00; sym_i = 2'b00; thresh_i = 16'h0000;
    last_sym = 2'b00;

    //            en    period  burst  mask   gaps  nsym  sct  bct
    tbl[0] = '{1'b0, 8'd15, 8'd1, 2'b11, 1'b0,  64,   0,   0};
    tbl[1] = '{1'b1, 8'd15, 8'd1, 2'b11, 1'b0, 256,  16,  32};
    tbl[2] = '{1'b1, 8'd4,  8'd3, 2'b01, 1'b1,  70,  30,  30};
    tbl[3] = '{1'b1, 8'd0,  8'd3, 2'b11, 1'b0,  24,   0,   0};
    tbl[4] = '{1'b1, 8'd3,  8'd0, 2'b11, 1'b0,  24,   0,   0};
    tbl[5] = '{1'b1, 8'd3,  8'd2, 2'b00, 1'b0,  24,   0,   0};
    tbl[6] = '{1'b1, 8'd1,  8'd1, 2'b11, 1'b0,  40,  20,  40};
    tbl[7] = '{1'b1, 8'd2,  8'd5, 2'b10, 1'b0,  21,  15,  15};

    do_reset();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_sym", {30'd0, sym_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_sct", {16'd0, err_sym_ct_o}, 32'd0);
    check("rst_bct", {16'd0, err_bit_ct_o}, 32'd0);

    for (int n = 0; n < 8; n++) begin
      sc = tbl[n];
      set_cfg(sc.en, sc.period, sc.burst, sc.mask);
      do_reset();
      for (int k = 0; k < sc.nsym; k++) begin
        if (sc.gaps) send(1'b0, 2'($urandom_range(0, 3)), 1'b0, sc.mask, $sformatf("sc%0d_gap", n));
        s = 2'($urandom_range(0, 3));
        bad = sc.en && (sc.period != 8'd0) && (sc.burst != 8'd0) && (sc.mask != 2'b00) &&
              ((k % (int'(sc.period) + int'(sc.burst))) >= int'(sc.period));
        send(1'b1, s, bad, sc.mask, $sformatf("sc%0d_k%0d", n, k));
      end
      sat_s = (sc.exp_sct > 15) ? 15 : sc.exp_sct;
      sat_b = (sc.exp_bct > 15) ? 15 : sc.exp_bct;
      check($sformatf("sc%0d_sct", n), {16'd0, err_sym_ct_o}, 32'(sc.exp_sct));
      check($sformatf("sc%0d_bct", n), {16'd0, err_bit_ct_o}, 32'(sc.exp_bct));
      check($sformatf("sc%0d_sat_sct", n), {28'd0, s_err_sym_ct_o}, 32'(sat_s));
      check($sformatf("sc%0d_sat_bct", n), {28'd0, s_err_bit_ct_o}, 32'(sat_b));
    end

    // Reset in the middle of a burst.
    set_cfg(1'b1, 8'd2, 8'd5, 2'b11);
    do_reset();
    send(1'b1, 2'b01, 1'b0, 2'b11, "rb_c0");
    send(1'b1, 2'b10, 1'b0, 2'b11, "rb_c1");
    send(1'b1, 2'b00, 1'b1, 2'b11, "rb_b0");
    send(1'b1, 2'b01, 1'b1, 2'b11, "rb_b1");
    rst = 1'b1;
    valid_i = 1'b1;
    sym_i = 2'b10;
    @(posedge clk);
    #1;
    check("rb_valid", {31'd0, valid_o}, 32'd0);
    check("rb_sym", {30'd0, sym_o}, 32'd0);
    check("rb_err", {31'd0, err_o}, 32'd0);
    check("rb_sct", {16'd0, err_sym_ct_o}, 32'd0);
    rst = 1'b0;
    valid_i = 1'b0;
    last_sym = 2'b00;
    send(1'b1, 2'b11, 1'b0, 2'b11, "rb_post0");
    send(1'b1, 2'b01, 1'b0, 2'b11, "rb_post1");
    send(1'b1, 2'b10, 1'b1, 2'b11, "rb_post2");

    // Period change mid-GAP only applies after the current burst.
    set_cfg(1'b1, 8'd3, 8'd1, 2'b11);
    do_reset();
    send(1'b1, 2'b00, 1'b0, 2'b11, "rc_0");
    period_i = 8'd1;
    send(1'b1, 2'b01, 1'b0, 2'b11, "rc_1");
    send(1'b1, 2'b10, 1'b0, 2'b11, "rc_2");
    send(1'b1, 2'b11, 1'b1, 2'b11, "rc_3");
    send(1'b1, 2'b00, 1'b0, 2'b11, "rc_4");
    send(1'b1, 2'b01, 1'b1, 2'b11, "rc_5");

    // Dropping en_i aborts the burst and re-enable starts a fresh GAP.
    set_cfg(1'b1, 8'd3, 8'd3, 2'b01);
    do_reset();
    for (int k = 0; k < 3; k++) send(1'b1, 2'(k), 1'b0, 2'b01, $sformatf("en_c%0d", k));
    send(1'b1, 2'b10, 1'b1, 2'b01, "en_b0");
    en_i = 1'b0;
    send(1'b1, 2'b11, 1'b0, 2'b01, "en_off0");
    send(1'b1, 2'b10, 1'b0, 2'b01, "en_off1");
    en_i = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b1, 2'(k + 1), 1'b0, 2'b01, $sformatf("en_re%0d", k));
    send(1'b1, 2'b00, 1'b1, 2'b01, "en_reb");
    check("en_sct", {16'd0, err_sym_ct_o}, 32'd2);

`ifdef CHAN_ERR_LFSR_EN
    // Random mode: threshold extremes and a rough 1/16 error rate.
    set_cfg(1'b1, 8'd3, 8'd1, 2'b11);
    mode_i = 1'b1;
    thresh_i = 16'h0000;
    do_reset();
    for (int k = 0; k < 64; k++) send(1'b1, 2'($urandom_range(0, 3)), 1'b0, 2'b11, $sformatf("r0_k%0d", k));
    check("r0_sct", {16'd0, err_sym_ct_o}, 32'd0);
    thresh_i = 16'hFFFF;
    do_reset();
    for (int k = 0; k < 64; k++) send(1'b1, 2'($urandom_range(0, 3)), 1'b1, 2'b11, $sformatf("rf_k%0d", k));
    check("rf_sct", {16'd0, err_sym_ct_o}, 32'd64);
    check("rf_bct", {16'd0, err_bit_ct_o}, 32'd128);
    thresh_i = 16'h1000;
    do_reset();
    valid_i = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      sym_i = 2'($urandom_range(0, 3));
      @(posedge clk);
    end
    #1;
    valid_i = 1'b0;
    cnt = int'(err_sym_ct_o);
    checks++;
    if (cnt >= 200 && cnt <= 320) passes++;
    else $display("FAIL r1k_rate: got %0d expected 200..320", cnt);
    mode_i = 1'b0;
`else
    // Without the LFSR build, mode_i/thresh_i are ignored: periodic pattern persists.
    set_cfg(1'b1, 8'd3, 8'd1, 2'b11);
    mode_i = 1'b1;
    thresh_i = 16'hFFFF;
    do_reset();
    for (int k = 0; k < 8; k++) send(1'b1, 2'(k), (k % 4) == 3, 2'b11, $sformatf("nm_k%0d", k));
    check("nm_sct", {16'd0, err_sym_ct_o}, 32'd2);
    mode_i = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
